mmio_controller: RTL and testbench
==================================

MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be honoured:
- WIDTH, 16: data word width.
- ADDR_WIDTH, 16: bus address width.
- NUM_CH, 4: number of IO channels; legal range 1..WIDTH-1.
- BASE_ADDR, 16'hFF00: first address of the register window.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- addr, in, ADDR_WIDTH: bus address.
- writeData, in, WIDTH: bus write data.
- writeEn, in, 1: bus write strobe.
- readEn, in, 1: bus read strobe.
- readData, out, WIDTH: registered read data.
- hit, out, 1: combinational; addr is inside the register window.
- ioInput, in, NUM_CH*WIDTH: external inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- ioOutput, out, NUM_CH*WIDTH: registered external outputs, same packing as ioInput.
- irq, out, 1: registered interrupt request.

Function
REQ-003 Register map SHALL use word offsets off = addr - BASE_ADDR, with hit=1 for 0 <= off < 2*NUM_CH+3 and hit=0 otherwise.
- 0..NUM_CH-1: IN[i], read-only, synchronised input of channel i.
- NUM_CH..2*NUM_CH-1: OUT[i], read/write, drives channel i of ioOutput.
- 2*NUM_CH: STATUS; bits [NUM_CH:0] are pending flags; a write clears each bit where writeData is 1 (W1C).
- 2*NUM_CH+1: IRQEN, read/write; bits [NUM_CH:0] are interrupt masks; other bits read 0.
- 2*NUM_CH+2: TIMER; a read returns the current count; a write loads the period.
REQ-004 Each ioInput channel SHALL pass through a 2-flop synchroniser; IN[i] is the second flop.
REQ-005 pending[i] SHALL set in the cycle after the second synchroniser flop differs from its value one cycle earlier.
REQ-006 Reads: if readEn & hit at edge N, readData SHALL present the addressed register at edge N+1 (1-cycle latency).
REQ-007 readData SHALL be 0 after a read with hit=0 and SHALL hold its value when readEn=0.
REQ-008 Writes SHALL take effect at the clock edge where writeEn & hit; writes to read-only offsets and writes with hit=0 SHALL be ignored.
REQ-009 If readEn and writeEn are both asserted to the same register, readData SHALL return the pre-write value.
REQ-010 If a pending bit's set event and its W1C clear occur in the same cycle, the set SHALL win.
REQ-011 Timer behaviour:
- period == 0: count held at 0, timer disabled.
- Otherwise count increments each cycle; when count == period, count goes to 0 and pending[NUM_CH] sets in that cycle.
- A period write SHALL reset count to 0.
REQ-012 irq SHALL equal the registered value of |(pending & IRQEN), so it lags pending or mask changes by one cycle.
REQ-013 ioOutput SHALL update at the same edge as the OUT write; there is no further delay.

Reset
REQ-014 While reset=1, asynchronously: readData=0, ioOutput=0, irq=0, pending=0, IRQEN=0, period=0, count=0, and all synchroniser flops=0.
REQ-015 After reset deasserts, a nonzero ioInput SHALL raise the corresponding pending bit 3 cycles later, because synchronisers start from 0.
REQ-016 Reset asserted during a read or write SHALL abort it; the register SHALL not be modified and readData SHALL be 0.

Verification (NUM_CH=4, BASE_ADDR=16'hFF00; window FF00-FF0A)
REQ-017 Output write/readback: write 16'hA5A5 to FF05 -> ioOutput[31:16]=A5A5 at the same edge; read FF05 -> readData=A5A5 one cycle later.
REQ-018 Input change and irq:
- Set IRQEN (write 16'h0004 to FF09).
- Change ioInput[47:32] from 0 to 16'h1234.
- Expect IN[2]=1234 after 2 cycles and STATUS=0004 after 3 cycles; irq=1 one cycle after that.
- Write 0004 to FF08 -> irq=0 one cycle later.
REQ-019 Timer:
- Write 3 to FF0A -> count sequence 0,1,2,3,0 and STATUS bit4 set at the wrap.
- Write 0 to FF0A -> count stays 0.
REQ-020 Set/clear race: W1C of bit0 in the same cycle as a new channel-0 change event -> STATUS bit0 remains 1.
REQ-021 Decode boundaries:
- Read FF0B or FEFF -> hit=0, readData=0.
- Write FF00 -> IN[0] unchanged.
- Assert reset mid-sequence -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/mmio_controller.sv
// Memory-mapped IO block: synchronised input channels, output registers,
// W1C status with interrupt masking, and a free-running period timer.
module mmio_controller #(
    parameter int                    WIDTH      = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    NUM_CH     = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'hFF00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [WIDTH-1:0]        writeData,
    input  logic                    writeEn,
    input  logic                    readEn,
    output logic [WIDTH-1:0]        readData,
    output logic                    hit,
    input  logic [NUM_CH*WIDTH-1:0] ioInput,
    output logic [NUM_CH*WIDTH-1:0] ioOutput,
    output logic                    irq
);

    localparam int NUM_REGS   = 2*NUM_CH + 3;
    localparam int OFF_STATUS = 2*NUM_CH;
    localparam int OFF_IRQEN  = 2*NUM_CH + 1;
    localparam int OFF_TIMER  = 2*NUM_CH + 2;
    localparam int PW         = NUM_CH + 1;
    localparam int BUS        = NUM_CH*WIDTH;

    logic [ADDR_WIDTH-1:0] offset;
    logic [BUS-1:0]        syncA;
    logic [BUS-1:0]        syncB;
    logic [BUS-1:0]        syncPrev;
    logic [PW-1:0]         pending;
    logic [PW-1:0]         irqEn;
    logic [PW-1:0]         setEvt;
    logic [PW-1:0]         clrMask;
    logic [WIDTH-1:0]      period;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      rdMux;
    logic [NUM_CH-1:0]     outWr;
    logic                  wrAccess;
    logic                  statusWr;
    logic                  irqEnWr;
    logic                  timerWr;
    logic                  timerWrap;

    // Unsigned wrap makes addresses below BASE_ADDR decode as out of window.
    assign offset   = addr - BASE_ADDR;
    assign hit      = (offset < ADDR_WIDTH'(NUM_REGS));
    assign wrAccess = writeEn & hit;
    assign statusWr = wrAccess && (offset == ADDR_WIDTH'(OFF_STATUS));
    assign irqEnWr  = wrAccess && (offset == ADDR_WIDTH'(OFF_IRQEN));
    assign timerWr  = wrAccess && (offset == ADDR_WIDTH'(OFF_TIMER));

    assign timerWrap = (period != '0) && (count == period);
    assign clrMask   = statusWr ? writeData[PW-1:0] : '0;

    always_comb begin
        outWr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            outWr[i] = wrAccess && (offset == ADDR_WIDTH'(NUM_CH + i));
        end
    end

    always_comb begin
        setEvt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            setEvt[i] = (syncB[i*WIDTH +: WIDTH] != syncPrev[i*WIDTH +: WIDTH]);
        end
        setEvt[NUM_CH] = timerWrap;
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (offset == ADDR_WIDTH'(i)) begin
                rdMux = syncB[i*WIDTH +: WIDTH];
            end
            if (offset == ADDR_WIDTH'(NUM_CH + i)) begin
                rdMux = ioOutput[i*WIDTH +: WIDTH];
            end
        end
        if (offset == ADDR_WIDTH'(OFF_STATUS)) begin
            rdMux = WIDTH'(pending);
        end
        if (offset == ADDR_WIDTH'(OFF_IRQEN)) begin
            rdMux = WIDTH'(irqEn);
        end
        if (offset == ADDR_WIDTH'(OFF_TIMER)) begin
            rdMux = count;
        end
    end

    // syncPrev is the IN value one cycle earlier, used only for change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncA    <= '0;
            syncB    <= '0;
            syncPrev <= '0;
        end else begin
            syncA    <= ioInput;
            syncB    <= syncA;
            syncPrev <= syncB;
        end
    end

    // Set has priority over a same-cycle W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            irqEn   <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~clrMask) | setEvt;
            irq     <= |(pending & irqEn);
            if (irqEnWr) begin
                irqEn <= writeData[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= '0;
            count  <= '0;
        end else if (timerWr) begin
            period <= writeData;
            count  <= '0;
        end else if ((period == '0) || timerWrap) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ioOutput <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (outWr[i]) begin
                    ioOutput[i*WIDTH +: WIDTH] <= writeData;
                end
            end
        end
    end

    // The mux samples pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData <= '0;
        end else if (readEn) begin
            readData <= hit ? rdMux : '0;
        end
    end

endmodule

// File: tb/tb_mmio_controller.sv
// Randomised and directed checks of mmio_controller against a cycle-level
// behavioural model of the register map, synchronisers and timer.
module tb_mmio_controller;

    localparam int          NCH  = 4;
    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] writeData = '0;
    logic        writeEn = 1'b0;
    logic        readEn = 1'b0;
    logic [15:0] readData;
    logic        hit;
    logic [63:0] ioInput = '0;
    logic [63:0] ioOutput;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_controller #(
        .WIDTH(16), .ADDR_WIDTH(16), .NUM_CH(NCH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .writeData(writeData),
        .writeEn(writeEn), .readEn(readEn), .readData(readData), .hit(hit),
        .ioInput(ioInput), .ioOutput(ioOutput), .irq(irq)
    );

    // Model state: hist[k] is ioInput as sampled k+1 edges ago (hist[1] is IN).
    logic [15:0] mOut [NCH];
    logic [63:0] hist [3];
    logic [4:0]  mPending = '0;
    logic [4:0]  mIrqEn = '0;
    logic [15:0] mPeriod = '0;
    logic [15:0] mRd = '0;
    int          mTicks = 0;
    logic        mIrq = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) mOut[i] = '0;
        for (int k = 0; k < 3; k++) hist[k] = '0;
        mPending = '0;
        mIrqEn   = '0;
        mPeriod  = '0;
        mRd      = '0;
        mTicks   = 0;
        mIrq     = 1'b0;
    endtask

    function automatic logic [15:0] timerCount();
        if (mPeriod == 0) return 16'h0;
        return 16'(mTicks % (int'(mPeriod) + 1));
    endfunction

    task automatic modelEdge();
        logic [15:0] off;
        logic [15:0] val;
        logic [15:0] cur;
        logic [4:0]  ev;
        logic [4:0]  clr;
        logic        inWin;
        int          o;
        off   = addr - BASE;
        inWin = off < 16'd11;
        o     = int'(off);
        cur   = timerCount();
        for (int i = 0; i < NCH; i++) ev[i] = hist[1][i*16 +: 16] != hist[2][i*16 +: 16];
        ev[4] = (mPeriod != 0) && (cur == mPeriod);
        val = 16'h0;
        if (o < NCH)           val = hist[1][o*16 +: 16];
        else if (o < 2*NCH)    val = mOut[o-NCH];
        else if (o == 2*NCH)   val = {11'h0, mPending};
        else if (o == 2*NCH+1) val = {11'h0, mIrqEn};
        else if (o == 2*NCH+2) val = cur;
        if (readEn) mRd = inWin ? val : 16'h0;
        clr  = (writeEn && inWin && o == 2*NCH) ? writeData[4:0] : 5'h0;
        mIrq = |(mPending & mIrqEn);
        mPending = (mPending & ~clr) | ev;
        mTicks++;
        if (writeEn && inWin) begin
            if (o >= NCH && o < 2*NCH) mOut[o-NCH] = writeData;
            if (o == 2*NCH+1) mIrqEn = writeData[4:0];
            if (o == 2*NCH+2) begin
                mPeriod = writeData;
                mTicks  = 0;
            end
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = ioInput;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelReset();
            else modelEdge();
        end
    end

    initial begin
        logic [15:0] off;
        logic [63:0] expOut;
        forever begin
            @(negedge clk);
            off = addr - BASE;
            expOut = {mOut[3], mOut[2], mOut[1], mOut[0]};
            check("model_hit", 64'(hit), 64'(off < 16'd11));
            check("model_readData", 64'(readData), 64'(mRd));
            check("model_ioOutput", ioOutput, expOut);
            check("model_irq", 64'(irq), 64'(mIrq));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic busOp(input logic [15:0] a, input logic [15:0] d, input logic we, input logic re);
        addr      = a;
        writeData = d;
        writeEn   = we;
        readEn    = re;
        @(posedge clk);
        #2;
        writeEn = 1'b0;
        readEn  = 1'b0;
    endtask

    initial begin
        logic [15:0] tseq [5];
        logic [15:0] a;
        logic [15:0] d;
        int          ch;
        tseq[0] = 16'd0; tseq[1] = 16'd1; tseq[2] = 16'd2; tseq[3] = 16'd3; tseq[4] = 16'd0;

        #1 reset = 1'b1;
        idle(2);
        check("reset_readData", 64'(readData), 64'h0);
        check("reset_ioOutput", ioOutput, 64'h0);
        check("reset_irq", 64'(irq), 64'h0);
        reset = 1'b0;
        idle(1);

        busOp(16'hFF05, 16'hA5A5, 1'b1, 1'b0);
        check("out1_same_edge", 64'(ioOutput[31:16]), 64'hA5A5);
        busOp(16'hFF05, 16'h0, 1'b0, 1'b1);
        check("out1_readback", 64'(readData), 64'hA5A5);

        busOp(16'hFF09, 16'h0004, 1'b1, 1'b0);
        ioInput[47:32] = 16'h1234;
        idle(2);
        busOp(16'hFF02, 16'h0, 1'b0, 1'b1);
        check("in2_after_2", 64'(readData), 64'h1234);
        check("irq_not_yet", 64'(irq), 64'h0);
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("status_ch2", 64'(readData), 64'h0004);
        check("irq_set", 64'(irq), 64'h1);
        busOp(16'hFF08, 16'h0004, 1'b1, 1'b0);
        check("irq_lags_clear", 64'(irq), 64'h1);
        idle(1);
        check("irq_cleared", 64'(irq), 64'h0);

        busOp(16'hFF0A, 16'd3, 1'b1, 1'b0);
        addr   = 16'hFF0A;
        readEn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            check("timer_seq", 64'(readData), 64'(tseq[k]));
        end
        readEn = 1'b0;
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("timer_status", 64'(readData), 64'h0010);
        busOp(16'hFF0A, 16'd0, 1'b1, 1'b0);
        busOp(16'hFF08, 16'h0010, 1'b1, 1'b0);
        idle(3);
        busOp(16'hFF0A, 16'h0, 1'b0, 1'b1);
        check("timer_disabled", 64'(readData), 64'h0);
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("status_clear", 64'(readData), 64'h0);

        ioInput[15:0] = 16'd1;
        idle(3);
        ioInput[15:0] = 16'd2;
        idle(2);
        busOp(16'hFF08, 16'h0001, 1'b1, 1'b0);
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("race_set_wins", 64'(readData), 64'h0001);
        busOp(16'hFF08, 16'h0001, 1'b1, 1'b0);
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("w1c_plain", 64'(readData), 64'h0);

        busOp(16'hFF05, 16'h0, 1'b0, 1'b1);
        addr   = 16'hFF0B;
        readEn = 1'b1;
        #1 check("hit_FF0B", 64'(hit), 64'h0);
        idle(1);
        readEn = 1'b0;
        check("miss_FF0B_read", 64'(readData), 64'h0);
        addr = 16'hFF0A;
        #1 check("hit_FF0A", 64'(hit), 64'h1);
        busOp(16'hFF05, 16'h0, 1'b0, 1'b1);
        addr   = 16'hFEFF;
        readEn = 1'b1;
        #1 check("hit_FEFF", 64'(hit), 64'h0);
        idle(1);
        readEn = 1'b0;
        check("miss_FEFF_read", 64'(readData), 64'h0);
        busOp(16'hFF00, 16'hFFFF, 1'b1, 1'b0);
        busOp(16'hFF00, 16'h0, 1'b0, 1'b1);
        check("in0_readonly", 64'(readData), 64'h0002);

        addr      = 16'hFF06;
        writeData = 16'h1111;
        writeEn   = 1'b1;
        reset     = 1'b1;
        #1;
        check("async_rst_readData", 64'(readData), 64'h0);
        check("async_rst_ioOutput", ioOutput, 64'h0);
        check("async_rst_irq", 64'(irq), 64'h0);
        @(posedge clk);
        #2;
        writeEn = 1'b0;
        reset   = 1'b0;
        check("aborted_write", ioOutput, 64'h0);
        idle(2);
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("post_reset_edge3", 64'(readData), 64'h0);
        busOp(16'hFF08, 16'h0, 1'b0, 1'b1);
        check("post_reset_edge4", 64'(readData), 64'h0005);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) a = 16'($urandom);
            else a = 16'(BASE - 16'd1 + 16'($urandom_range(0, 12)));
            d = (a == 16'hFF0A) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ch = $urandom_range(0, NCH-1);
                ioInput[ch*16 +: 16] = 16'($urandom);
            end
            addr      = a;
            writeData = d;
            writeEn   = ($urandom_range(0, 99) < 40);
            readEn    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end else begin
                idle(1);
            end
        end
        writeEn = 1'b0;
        readEn  = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
